// File: rtl/enemy_bullet_pool_pkg.sv
// Shared constants and slot record for the enemy/boss bullet pool.
package enemy_bullet_pool_pkg;
   localparam int N_SLOTS = 12;
   localparam int N_REQ   = 5;

   localparam logic [9:0]  PARK       = 10'd1023;
   localparam logic [10:0] PLAY_Y_MAX = 11'd470;
   localparam logic [9:0]  PLAY_X_MIN = 10'd185;
   localparam logic [9:0]  PLAY_X_MAX = 10'd503;

   localparam logic [1:0]  ENM_DY    = 2'd2;
   localparam logic [1:0]  BOSS_DY   = 2'd3;
   localparam logic [9:0]  SPAWN_OFS = 10'd20;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] dy;
      logic       active;
   } slot_t;

   // Parked coordinates sit outside every renderer window, so the slot is invisible.
   function automatic slot_t park_slot();
      slot_t s;
      s.x      = PARK;
      s.y      = PARK;
      s.dy     = 2'd0;
      s.active = 1'b0;
      return s;
   endfunction
endpackage

// File: rtl/enemy_bullet_pool_if.sv
// Shot request/grant bundle between the shooters and the bullet pool.
interface enemy_bullet_pool_if;
   import enemy_bullet_pool_pkg::*;

   logic [N_REQ-1:0]    req;
   logic [N_REQ*10-1:0] req_x;
   logic [N_REQ*10-1:0] req_y;
   logic [N_REQ-1:0]    grant;

   modport master (output req, output req_x, output req_y, input grant);
   modport slave  (input req, input req_x, input req_y, output grant);
endinterface

// File: rtl/enemy_bullet_pool_arb.sv
// 5-way round-robin arbiter; search starts at the pointer, masked requesters are skipped.
module rr_arbiter5
   import enemy_bullet_pool_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [4:0] req_i,
   input  logic [4:0] mask_i,
   output logic [4:0] gnt_o
);
   logic [2:0] ptr_q, ptr_d;
   logic [4:0] cand;
   logic [3:0] idx;
   logic [2:0] idx3;
   logic       found;

   always_comb begin
      cand  = req_i & ~mask_i & {5{en_i}};
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      idx3  = '0;
      for (int k = 0; k < 5; k++) begin
         idx = {1'b0, ptr_q} + 4'(k);
         if (idx >= 4'd5) idx = idx - 4'd5;
         idx3 = idx[2:0];
         if (!found && cand[idx3]) begin
            found       = 1'b1;
            gnt_o[idx3] = 1'b1;
            ptr_d       = (idx3 == 3'd4) ? 3'd0 : idx3 + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= 3'd0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/enemy_bullet_pool.sv
// Twelve-slot enemy/boss bullet pool: allocation, per-frame movement and retirement.
module enemy_bullet_pool
   import enemy_bullet_pool_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_tick,
   input  logic                  clear_all,
   enemy_bullet_pool_if.slave    shot,
   input  logic [N_SLOTS-1:0]    hit_slot,
   output logic [N_SLOTS*10-1:0] bullet_x,
   output logic [N_SLOTS*10-1:0] bullet_y,
   output logic [N_SLOTS-1:0]    slot_active,
   output logic                  pool_full
);
   slot_t            slot_q [N_SLOTS];
   slot_t            slot_d [N_SLOTS];
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] gnt;
   logic             alloc;
   logic [2:0]       gidx;
   logic [3:0]       free_idx;
   slot_t            new_slot;
   logic [10:0]      y_next;

   // The previous grant is masked so a requester still holding req is not served twice.
   rr_arbiter5 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (~clear_all & ~frame_tick & ~pool_full),
      .req_i  (shot.req),
      .mask_i (grant_q),
      .gnt_o  (gnt)
   );

   always_comb begin
      free_idx = '0;
      for (int s = N_SLOTS - 1; s >= 0; s--) begin
         if (!slot_q[s].active) free_idx = 4'(s);
      end
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) gidx = 3'(i);
      end
      alloc           = |gnt;
      new_slot.x      = shot.req_x[int'(gidx)*10 +: 10];
      new_slot.y      = shot.req_y[int'(gidx)*10 +: 10] + SPAWN_OFS;
      new_slot.dy     = (gidx == 3'd4) ? BOSS_DY : ENM_DY;
      new_slot.active = 1'b1;
   end

   // Per-slot priority: flush, hit, movement, allocation.
   always_comb begin
      y_next = '0;
      for (int s = 0; s < N_SLOTS; s++) begin
         slot_d[s] = slot_q[s];
         if (clear_all) begin
            slot_d[s] = park_slot();
         end else if (hit_slot[s] && slot_q[s].active) begin
            slot_d[s] = park_slot();
         end else if (frame_tick && slot_q[s].active) begin
            y_next = {1'b0, slot_q[s].y} + {9'b0, slot_q[s].dy};
            if (y_next > PLAY_Y_MAX) slot_d[s] = park_slot();
            else                     slot_d[s].y = y_next[9:0];
         end else if (alloc && free_idx == 4'(s)) begin
            slot_d[s] = new_slot;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q <= '0;
         for (int s = 0; s < N_SLOTS; s++) slot_q[s] <= park_slot();
      end else begin
         grant_q <= gnt;
         for (int s = 0; s < N_SLOTS; s++) slot_q[s] <= slot_d[s];
      end
   end

   always_comb begin
      for (int s = 0; s < N_SLOTS; s++) begin
         bullet_x[s*10 +: 10] = slot_q[s].x;
         bullet_y[s*10 +: 10] = slot_q[s].y;
         slot_active[s]       = slot_q[s].active;
      end
   end

   assign pool_full  = &slot_active;
   assign shot.grant = grant_q;
endmodule
